// File: rtl/multibus_pkg.sv
// Shared definitions for the FX2 multibus register path: FSM state encoding,
// bus word type and the default register count used on both sides.
package multibus_pkg;

    // Number of 32-bit registers carried on the multibus by default.
    localparam int REG_COUNT_DEFAULT = 16;

    // Width of one register word on the bus.
    localparam int WORD_W = 32;

    // Width of the stability counter; wide enough for the largest legal
    // STABLE_CNT of 15.
    localparam int STABLE_CNT_W = 4;

    // One register word as seen on the bus and in the shadow copy.
    typedef logic [WORD_W-1:0] word_t;

    // Capture FSM states.
    typedef enum logic [1:0] {
        ST_SCAN   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage : multibus_pkg

// File: rtl/multibus_sync2.sv
// Two-flop synchroniser for a bus that is asynchronous to the local clock.
// Individual bits may resolve on different cycles; consumers are expected to
// qualify multi-bit values (the capture FSM does this by requiring a word to
// be seen unchanged for several consecutive samples).
module multibus_sync2 #(
    parameter int WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_n_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    // Shift the raw bus through two register stages every cycle.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= data_i;
            sync2_q <= sync1_q;
        end
    end

    assign data_o = sync2_q;

endmodule : multibus_sync2

// File: rtl/multibus_capture.sv
// Captures register words written by the FX2 side into a clock-domain shadow
// copy. Words are scanned round-robin; a word that differs from its shadow is
// only committed once it has been sampled unchanged STABLE_CNT times in a row,
// so partially-updated (torn) words never reach regs_all.
module multibus_capture
    import multibus_pkg::*;
#(
    parameter int REG_COUNT  = REG_COUNT_DEFAULT,
    parameter int STABLE_CNT = 3
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [REG_COUNT*WORD_W-1:0] multibus_out_all,
    input  logic [REG_COUNT-1:0]        clr_flags,
    output logic [REG_COUNT*WORD_W-1:0] regs_all,
    output logic                        upd_stb,
    output logic [7:0]                  upd_idx,
    output logic [WORD_W-1:0]           upd_data,
    output logic [REG_COUNT-1:0]        upd_flags
);

    localparam int                     IDX_W    = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;
    localparam logic [IDX_W-1:0]       IDX_LAST = IDX_W'(REG_COUNT - 1);
    localparam logic [STABLE_CNT_W-1:0] CNT_ONE  = STABLE_CNT_W'(1);
    localparam logic [STABLE_CNT_W-1:0] CNT_DONE = STABLE_CNT_W'(STABLE_CNT);

    // ------------------------------------------------------------------
    // Synchronised bus and per-word views
    // ------------------------------------------------------------------
    logic [REG_COUNT*WORD_W-1:0] sync2_all;
    word_t                       sync_words [REG_COUNT];
    word_t                       shadow_q   [REG_COUNT];

    multibus_sync2 #(
        .WIDTH (REG_COUNT * WORD_W)
    ) u_sync (
        .clock_i   (clock),
        .reset_n_i (reset_n),
        .data_i    (multibus_out_all),
        .data_o    (sync2_all)
    );

    // ------------------------------------------------------------------
    // FSM state
    // ------------------------------------------------------------------
    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [STABLE_CNT_W-1:0] cnt_q, cnt_d;
    word_t                   cand_q, cand_d;

    logic                    upd_stb_q, upd_stb_d;
    logic [7:0]              upd_idx_q, upd_idx_d;
    word_t                   upd_data_q, upd_data_d;
    logic [REG_COUNT-1:0]    flags_q, flags_d;
    logic [REG_COUNT-1:0]    set_mask;

    word_t                   cur_word;
    word_t                   cur_shadow;
    logic [IDX_W-1:0]        idx_inc;
    logic [STABLE_CNT_W-1:0] cnt_inc;

    assign cur_word   = sync_words[idx_q];
    assign cur_shadow = shadow_q[idx_q];
    assign idx_inc    = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    assign cnt_inc    = cnt_q + CNT_ONE;

    genvar gi;
    generate
        for (gi = 0; gi < REG_COUNT; gi++) begin : g_word
            assign sync_words[gi]                    = sync2_all[gi*WORD_W +: WORD_W];
            assign regs_all[gi*WORD_W +: WORD_W]     = shadow_q[gi];
            assign set_mask[gi] = (state_q == ST_COMMIT) && (idx_q == IDX_W'(gi));

            // Shadow word gi is only ever written whole, from a verified
            // candidate, in the COMMIT state.
            always_ff @(posedge clock) begin
                if (!reset_n) begin
                    shadow_q[gi] <= '0;
                end else if (set_mask[gi]) begin
                    shadow_q[gi] <= cand_q;
                end
            end
        end
    endgenerate

    // Next-state logic: scan for a differing word, verify it is stable, commit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;

        case (state_q)
            ST_SCAN: begin
                if (cur_word == cur_shadow) begin
                    idx_d = idx_inc;
                end else begin
                    cand_d  = cur_word;
                    cnt_d   = CNT_ONE;
                    state_d = ST_VERIFY;
                end
            end

            ST_VERIFY: begin
                if (cur_word == cand_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_DONE) begin
                        state_d = ST_COMMIT;
                    end
                end else if (cur_word == cur_shadow) begin
                    // The change reverted before settling: treat as a glitch.
                    state_d = ST_SCAN;
                    idx_d   = idx_inc;
                    cnt_d   = '0;
                end else begin
                    // Still moving: restart the stability count on the new value.
                    cand_d = cur_word;
                    cnt_d  = CNT_ONE;
                end
            end

            ST_COMMIT: begin
                state_d = ST_SCAN;
                idx_d   = idx_inc;
                cnt_d   = '0;
            end

            default: begin
                state_d = ST_SCAN;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobe and flag next values. The strobe is registered on entry to COMMIT
    // so it is high exactly during the COMMIT cycle; COMMIT always returns to
    // SCAN, which keeps strobes at least two cycles apart.
    always_comb begin
        upd_stb_d  = (state_d == ST_COMMIT);
        upd_idx_d  = upd_idx_q;
        upd_data_d = upd_data_q;
        if (upd_stb_d) begin
            upd_idx_d  = 8'(idx_q);
            upd_data_d = cand_q;
        end
        // Set has priority over a simultaneous clear.
        flags_d = (flags_q & ~clr_flags) | set_mask;
    end

    // FSM and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ST_SCAN;
            idx_q      <= '0;
            cnt_q      <= '0;
            cand_q     <= '0;
            upd_stb_q  <= 1'b0;
            upd_idx_q  <= '0;
            upd_data_q <= '0;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            upd_stb_q  <= upd_stb_d;
            upd_idx_q  <= upd_idx_d;
            upd_data_q <= upd_data_d;
            flags_q    <= flags_d;
        end
    end

    assign upd_stb   = upd_stb_q;
    assign upd_idx   = upd_idx_q;
    assign upd_data  = upd_data_q;
    assign upd_flags = flags_q;

endmodule : multibus_capture
